// File: rtl/tlc_phase_arbiter.sv
// Purpose: round-robin right-of-way arbiter for N mutually exclusive traffic phases with green/yellow/all-red timing.
// Latency: a request latched at edge t is visible in pending at t+1; green starts at t+2 from IDLE.
// Backpressure: none; sensor requests are sticky in pending until their phase is granted.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req             raw per-phase sensor inputs (sampled every edge)
//   grant/yellow    one-hot lamp drives, all zero when not in that class
//   all_red         high in IDLE and CLEAR
//   active_phase    index of the phase that currently owns (or last owned) the lamps
//   pending         latched, not yet served requests
//
// Build option: define TLC_PREEMPT_EN to add preempt_req/preempt_phase inputs and the
// preempt_active output. A preempting phase is served without moving the round-robin pointer.
module tlc_phase_arbiter #(
    parameter int N_PHASES  = 5,
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 10,
    parameter int GAP       = 5,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1,
    parameter int CW        = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PHASES-1:0]         req,
`ifdef TLC_PREEMPT_EN
    input  logic                        preempt_req,
    input  logic [$clog2(N_PHASES)-1:0] preempt_phase,
    output logic                        preempt_active,
`endif
    output logic [N_PHASES-1:0]         grant,
    output logic [N_PHASES-1:0]         yellow,
    output logic                        all_red,
    output logic [$clog2(N_PHASES)-1:0] active_phase,
    output logic [N_PHASES-1:0]         pending
);

    localparam int PW = $clog2(N_PHASES);

    // Elaboration-time parameter sanity checks.
    if (N_PHASES < 2) begin : g_chk_n
        $error("tlc_phase_arbiter: N_PHASES must be >= 2");
    end
    if (MIN_GREEN < 1) begin : g_chk_min
        $error("tlc_phase_arbiter: MIN_GREEN must be >= 1");
    end
    if (YELLOW < 1) begin : g_chk_yel
        $error("tlc_phase_arbiter: YELLOW must be >= 1");
    end
    if (ALL_RED < 1) begin : g_chk_ar
        $error("tlc_phase_arbiter: ALL_RED must be >= 1");
    end
    if (MAX_GREEN < MIN_GREEN) begin : g_chk_max
        $error("tlc_phase_arbiter: MAX_GREEN must be >= MIN_GREEN");
    end
    if (CW < 2 || CW > 30) begin : g_chk_cw
        $error("tlc_phase_arbiter: CW must be in 2..30");
    end

    // Thresholds are clamped to the saturating timer range so a large parameter
    // behaves as "never reached before saturation" rather than wrapping.
    function automatic logic [CW-1:0] tclamp(input int v);
        if (longint'(v) >= (longint'(1) << CW) - 1) begin
            return {CW{1'b1}};
        end
        return CW'(v);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    localparam logic [CW-1:0]       MIN_G    = tclamp(MIN_GREEN);
    localparam logic [CW-1:0]       MAX_G    = tclamp(MAX_GREEN);
    localparam logic [CW-1:0]       GAP_T    = tclamp(GAP);
    localparam logic [CW-1:0]       YEL_T    = tclamp(YELLOW);
    localparam logic [CW-1:0]       AR_T     = tclamp(ALL_RED);
    localparam logic [PW-1:0]       LAST_RST = PW'(N_PHASES - 1);
    localparam logic [N_PHASES-1:0] ONE      = N_PHASES'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_CLEAR
    } state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       cur_phase, cur_nxt;   // phase owning the lamps
    logic [PW-1:0]       last, last_nxt;       // round-robin pointer
    logic [CW-1:0]       g_cnt, g_nxt;         // green cycles, 1 on first green cycle
    logic [CW-1:0]       gap_cnt, gap_nxt;     // trailing no-request green cycles, previous cycles
    logic [CW-1:0]       tmr, tmr_nxt;         // yellow / clear cycle counter
    logic [N_PHASES-1:0] pend_nxt;

    logic [N_PHASES-1:0] cur_oh;
    logic [CW-1:0]       gap_cur;
    logic                win_vld;
    logic [PW-1:0]       win_idx;
    int                  scan_idx;
    logic                sel_vld;
    logic [PW-1:0]       sel_idx;
    logic                sel_rr;
    logic                green_exit;
    logic                take;

    assign cur_oh = ONE << cur_phase;

    assign grant        = (state == S_GREEN)  ? cur_oh : '0;
    assign yellow       = (state == S_YELLOW) ? cur_oh : '0;
    assign all_red      = (state == S_IDLE) || (state == S_CLEAR);
    assign active_phase = cur_phase;

`ifdef TLC_PREEMPT_EN
    assign preempt_active = preempt_req;
`endif

    // Gap including the current cycle: any request from the green phase restarts it.
    assign gap_cur = req[cur_phase] ? '0 : sat_inc(gap_cnt);

    // Round-robin scan starting at last+1. Iterating from the farthest offset down
    // lets the nearest pending phase overwrite, and offset N (last itself) ranks lowest.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        for (int k = N_PHASES; k >= 1; k--) begin
            scan_idx = (int'(last) + k) % N_PHASES;
            if (pending[PW'(scan_idx)]) begin
                win_vld = 1'b1;
                win_idx = PW'(scan_idx);
            end
        end
    end

    // Selection used by IDLE and the last CLEAR cycle; a preemption overrides
    // round-robin and does not advance the pointer.
    always_comb begin
        sel_vld = win_vld;
        sel_idx = win_idx;
        sel_rr  = 1'b1;
`ifdef TLC_PREEMPT_EN
        if (preempt_req) begin
            sel_vld = 1'b1;
            sel_idx = preempt_phase;
            sel_rr  = 1'b0;
        end
`endif
    end

    // Green termination. MAX_GREEN only bites when someone else is waiting.
    always_comb begin
        green_exit = (g_cnt >= MIN_G) &&
                     ((gap_cur >= GAP_T) || ((g_cnt >= MAX_G) && (|pending)));
`ifdef TLC_PREEMPT_EN
        if (preempt_req) begin
            green_exit = (cur_phase != preempt_phase);
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_phase;
        last_nxt  = last;
        g_nxt     = g_cnt;
        gap_nxt   = gap_cnt;
        tmr_nxt   = tmr;
        take      = 1'b0;
        // The green phase cannot re-latch its own request while it is being served.
        pend_nxt  = pending | (req & ~grant);

        unique case (state)
            S_IDLE: begin
                if (sel_vld) begin
                    take = 1'b1;
                end
            end
            S_GREEN: begin
                if (green_exit) begin
                    state_nxt = S_YELLOW;
                    tmr_nxt   = CW'(1);
                    g_nxt     = '0;
                    gap_nxt   = '0;
                end else begin
                    g_nxt   = sat_inc(g_cnt);
                    gap_nxt = gap_cur;
                end
            end
            S_YELLOW: begin
                if (tmr >= YEL_T) begin
                    state_nxt = S_CLEAR;
                    tmr_nxt   = CW'(1);
                end else begin
                    tmr_nxt = sat_inc(tmr);
                end
            end
            S_CLEAR: begin
                if (tmr >= AR_T) begin
                    if (sel_vld) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        tmr_nxt   = '0;
                    end
                end else begin
                    tmr_nxt = sat_inc(tmr);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Entering green: clearing pending here takes precedence over a same-edge set.
        if (take) begin
            state_nxt         = S_GREEN;
            cur_nxt           = sel_idx;
            g_nxt             = CW'(1);
            gap_nxt           = '0;
            tmr_nxt           = '0;
            pend_nxt[sel_idx] = 1'b0;
            if (sel_rr) begin
                last_nxt = sel_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_phase <= LAST_RST;
            last      <= LAST_RST;
            g_cnt     <= '0;
            gap_cnt   <= '0;
            tmr       <= '0;
            pending   <= '0;
        end else begin
            state     <= state_nxt;
            cur_phase <= cur_nxt;
            last      <= last_nxt;
            g_cnt     <= g_nxt;
            gap_cnt   <= gap_nxt;
            tmr       <= tmr_nxt;
            pending   <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Purpose: directed self-checking bench for tlc_phase_arbiter with default parameters.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled in the same slot.
// Backpressure: not applicable; every scenario runs a fixed number of cycles.
module tb_tlc_phase_arbiter;

    logic       clk;
    logic       reset;
    logic [4:0] req;
    logic [4:0] grant;
    logic [4:0] yellow;
    logic       all_red;
    logic [2:0] active_phase;
    logic [4:0] pending;
`ifdef TLC_PREEMPT_EN
    logic       preempt_req;
    logic [2:0] preempt_phase;
    logic       preempt_active;
`endif

    int checks;
    int errors;

    tlc_phase_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
`ifdef TLC_PREEMPT_EN
        .preempt_req    (preempt_req),
        .preempt_phase  (preempt_phase),
        .preempt_active (preempt_active),
`endif
        .grant          (grant),
        .yellow         (yellow),
        .all_red        (all_red),
        .active_phase   (active_phase),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at "cycle 0": DUT in its reset state, reset deasserted.
    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL reset_grant got %b want %b", grant, 5'b00000); end
        checks++; if (yellow !== 5'b00000) begin errors++; $display("FAIL reset_yellow got %b want %b", yellow, 5'b00000); end
        checks++; if (all_red !== 1'b1) begin errors++; $display("FAIL reset_all_red got %b want %b", all_red, 1'b1); end
        checks++; if (pending !== 5'b00000) begin errors++; $display("FAIL reset_pending got %b want %b", pending, 5'b00000); end
        checks++; if (active_phase !== 3'd4) begin errors++; $display("FAIL reset_active_phase got %0d want %0d", active_phase, 4); end
    endtask

    // req[2] held: latched at cycle 1, green from cycle 2 and held; then gap behaviour.
    task automatic test_hold_and_gap;
        do_reset();
        req = 5'b00100;
        tick(); // cycle 1
        checks++; if (pending !== 5'b00100) begin errors++; $display("FAIL hold_pending_c1 got %b want %b", pending, 5'b00100); end
        checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL hold_grant_c1 got %b want %b", grant, 5'b00000); end
        tick(); // cycle 2
        checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL hold_grant_c2 got %b want %b", grant, 5'b00100); end
        checks++; if (all_red !== 1'b0) begin errors++; $display("FAIL hold_all_red_c2 got %b want %b", all_red, 1'b0); end
        checks++; if (pending !== 5'b00000) begin errors++; $display("FAIL hold_pending_c2 got %b want %b", pending, 5'b00000); end
        checks++; if (active_phase !== 3'd2) begin errors++; $display("FAIL hold_active_c2 got %0d want %0d", active_phase, 2); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (grant !== 5'b00100 || all_red !== 1'b0) begin errors++; $display("FAIL hold_green_%0d got grant %b all_red %b want grant %b all_red 0", i, grant, all_red, 5'b00100); end
        end
        // Request absent 3 cycles, present 1, then absent: green lasts 3+1+5 cycles.
        for (int i = 0; i < 10; i++) begin
            req = (i == 3) ? 5'b00100 : 5'b00000;
            checks++; if (grant !== ((i < 9) ? 5'b00100 : 5'b00000)) begin errors++; $display("FAIL gap_grant_%0d got %b want %b", i, grant, (i < 9) ? 5'b00100 : 5'b00000); end
            checks++; if (yellow !== ((i == 9) ? 5'b00100 : 5'b00000)) begin errors++; $display("FAIL gap_yellow_%0d got %b want %b", i, yellow, (i == 9) ? 5'b00100 : 5'b00000); end
            checks++; if (pending !== 5'b00000) begin errors++; $display("FAIL gap_pending_%0d got %b want %b", i, pending, 5'b00000); end
            tick();
        end
        req = '0;
    endtask

    // One-cycle pulse: 5 green, 2 yellow, then all-red (CLEAR then IDLE).
    task automatic test_pulse;
        logic [4:0] exp_g;
        logic [4:0] exp_y;
        logic       exp_r;
        do_reset();
        req = 5'b00100;
        tick(); // cycle 1
        req = 5'b00000;
        checks++; if (pending !== 5'b00100) begin errors++; $display("FAIL pulse_pending_c1 got %b want %b", pending, 5'b00100); end
        tick(); // cycle 2
        for (int i = 0; i < 11; i++) begin
            exp_g = (i < 5) ? 5'b00100 : 5'b00000;
            exp_y = (i == 5 || i == 6) ? 5'b00100 : 5'b00000;
            exp_r = (i >= 7);
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL pulse_grant_%0d got %b want %b", i, grant, exp_g); end
            checks++; if (yellow !== exp_y) begin errors++; $display("FAIL pulse_yellow_%0d got %b want %b", i, yellow, exp_y); end
            checks++; if (all_red !== exp_r) begin errors++; $display("FAIL pulse_all_red_%0d got %b want %b", i, all_red, exp_r); end
            tick();
        end
        checks++; if (pending !== 5'b00000) begin errors++; $display("FAIL pulse_pending_end got %b want %b", pending, 5'b00000); end
    endtask

    // req[0] and req[3] held: max-green alternation 0 -> 3 -> 0.
    task automatic test_back_to_back;
        logic [4:0] exp_g;
        logic [4:0] exp_y;
        logic       exp_r;
        logic [2:0] exp_a;
        do_reset();
        req = 5'b01001;
        tick();
        tick(); // cycle 2
        for (int i = 0; i < 27; i++) begin
            exp_g = 5'b00000;
            exp_y = 5'b00000;
            exp_r = 1'b0;
            if (i <= 9) exp_g = 5'b00001;
            else if (i <= 11) exp_y = 5'b00001;
            else if (i == 12) exp_r = 1'b1;
            else if (i <= 22) exp_g = 5'b01000;
            else if (i <= 24) exp_y = 5'b01000;
            else if (i == 25) exp_r = 1'b1;
            else exp_g = 5'b00001;
            exp_a = (i <= 12) ? 3'd0 : ((i <= 25) ? 3'd3 : 3'd0);
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL b2b_grant_%0d got %b want %b", i, grant, exp_g); end
            checks++; if (yellow !== exp_y) begin errors++; $display("FAIL b2b_yellow_%0d got %b want %b", i, yellow, exp_y); end
            checks++; if (all_red !== exp_r) begin errors++; $display("FAIL b2b_all_red_%0d got %b want %b", i, all_red, exp_r); end
            checks++; if (active_phase !== exp_a) begin errors++; $display("FAIL b2b_active_%0d got %0d want %0d", i, active_phase, exp_a); end
            tick();
        end
        req = '0;
    endtask

    // last=4 with pending {0,4} at CLEAR end: wrap to phase 0, phase 4 keeps waiting.
    task automatic test_clear_wrap;
        do_reset();
        req = 5'b10000;
        tick(); // cycle 1
        req = 5'b00000;
        repeat (6) tick(); // cycle 7, first yellow cycle
        checks++; if (yellow !== 5'b10000) begin errors++; $display("FAIL wrap_yellow_c7 got %b want %b", yellow, 5'b10000); end
        req = 5'b10001;
        tick(); // cycle 8
        req = 5'b00000;
        checks++; if (pending !== 5'b10001) begin errors++; $display("FAIL wrap_pending_c8 got %b want %b", pending, 5'b10001); end
        tick(); // cycle 9, CLEAR
        checks++; if (all_red !== 1'b1) begin errors++; $display("FAIL wrap_all_red_c9 got %b want %b", all_red, 1'b1); end
        checks++; if (active_phase !== 3'd4) begin errors++; $display("FAIL wrap_active_c9 got %0d want %0d", active_phase, 4); end
        tick(); // cycle 10
        checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL wrap_grant_c10 got %b want %b", grant, 5'b00001); end
        checks++; if (active_phase !== 3'd0) begin errors++; $display("FAIL wrap_active_c10 got %0d want %0d", active_phase, 0); end
        checks++; if (pending !== 5'b10000) begin errors++; $display("FAIL wrap_pending_c10 got %b want %b", pending, 5'b10000); end
        repeat (8) tick(); // cycle 18
        checks++; if (grant !== 5'b10000) begin errors++; $display("FAIL wrap_grant_c18 got %b want %b", grant, 5'b10000); end
        checks++; if (pending !== 5'b00000) begin errors++; $display("FAIL wrap_pending_c18 got %b want %b", pending, 5'b00000); end
    endtask

    // Reset during yellow[1] with phase 3 waiting.
    task automatic test_reset_mid_yellow;
        do_reset();
        req = 5'b00010;
        tick(); // cycle 1
        req = 5'b00000;
        tick();
        tick(); // cycle 3
        req = 5'b01000;
        tick(); // cycle 4
        req = 5'b00000;
        repeat (3) tick(); // cycle 7
        checks++; if (yellow !== 5'b00010) begin errors++; $display("FAIL rsty_yellow_c7 got %b want %b", yellow, 5'b00010); end
        checks++; if (pending !== 5'b01000) begin errors++; $display("FAIL rsty_pending_c7 got %b want %b", pending, 5'b01000); end
        reset = 1'b1;
        tick();
        checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL rsty_grant got %b want %b", grant, 5'b00000); end
        checks++; if (yellow !== 5'b00000) begin errors++; $display("FAIL rsty_yellow got %b want %b", yellow, 5'b00000); end
        checks++; if (pending !== 5'b00000) begin errors++; $display("FAIL rsty_pending got %b want %b", pending, 5'b00000); end
        checks++; if (all_red !== 1'b1) begin errors++; $display("FAIL rsty_all_red got %b want %b", all_red, 1'b1); end
        checks++; if (active_phase !== 3'd4) begin errors++; $display("FAIL rsty_active got %0d want %0d", active_phase, 4); end
        reset = 1'b0;
    endtask

`ifdef TLC_PREEMPT_EN
    task automatic test_preempt;
        logic [4:0] exp_g;
        logic [4:0] exp_y;
        do_reset();
        req = 5'b00001;
        tick(); // cycle 1
        req = 5'b00000;
        tick(); // cycle 2, phase 0 green cycle 1
        preempt_req   = 1'b1;
        preempt_phase = 3'd4;
        checks++; if (preempt_active !== 1'b1) begin errors++; $display("FAIL pre_active got %b want %b", preempt_active, 1'b1); end
        for (int i = 0; i < 7; i++) begin
            exp_g = (i == 0) ? 5'b00001 : ((i >= 4) ? 5'b10000 : 5'b00000);
            exp_y = (i == 1 || i == 2) ? 5'b00001 : 5'b00000;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL pre_grant_%0d got %b want %b", i, grant, exp_g); end
            checks++; if (yellow !== exp_y) begin errors++; $display("FAIL pre_yellow_%0d got %b want %b", i, yellow, exp_y); end
            tick();
        end
        preempt_req = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = '0;
`ifdef TLC_PREEMPT_EN
        preempt_req   = 1'b0;
        preempt_phase = '0;
`endif
        test_reset();
        test_hold_and_gap();
        test_pulse();
        test_back_to_back();
        test_clear_wrap();
        test_reset_mid_yellow();
`ifdef TLC_PREEMPT_EN
        test_preempt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
